dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 17 +
 rtl/dmem_arbiter_rr.sv | 19 +
 rtl/dmem_arbiter.sv | 137 +++++++++++++
 tb/tb_dmem_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory burst arbiter:
// parameter defaults, FSM state encoding and small helpers.
package dmem_arbiter_pkg;

  localparam int unsigned DMEM_ADDR_W = 7;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_LEN_W  = 3;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  // Port number (0/1) to one-hot per-port vector.
  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-request round-robin grant: on contention the port that did not own
// the previous burst wins.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_owner_i ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port burst arbiter in front of a single-port data memory. A granted
// port owns the memory for len+1 beats; read data returns one cycle later.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned LEN_W  = DMEM_LEN_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            req_i,
  input  logic [1:0]            we_i,
  input  logic [2*ADDR_W-1:0]   addr_i,
  input  logic [2*LEN_W-1:0]    len_i,
  input  logic [2*DATA_W-1:0]   wdata_i,
  output logic [1:0]            ack_o,
  output logic                  last_o,
  output logic [1:0]            rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic [DATA_W-1:0]     mem_rdata_i
);

  logic              state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rvalid_q, rvalid_d;

  logic [1:0]        gnt;
  logic              gnt_port;
  logic [ADDR_W-1:0] gnt_addr;
  logic [LEN_W-1:0]  gnt_len;
  logic              gnt_we;
  logic [DATA_W-1:0] own_wdata;
  logic              beat;

  rr_arbiter2 u_rr (
    .req_i        (req_i),
    .last_owner_i (last_owner_q),
    .gnt_o        (gnt)
  );

  assign gnt_port  = gnt[1];
  assign gnt_addr  = gnt_port ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
  assign gnt_len   = gnt_port ? len_i[2*LEN_W-1:LEN_W]    : len_i[LEN_W-1:0];
  assign gnt_we    = gnt_port ? we_i[1] : we_i[0];
  assign own_wdata = owner_q ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];

  // A beat happens only while the owner keeps its request up; dropping it
  // aborts the burst without touching memory that cycle.
  assign beat = (state_q == ST_BURST) && (owner_q ? req_i[1] : req_i[0]);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    rvalid_d     = '0;

    ack_o        = '0;
    last_o       = 1'b0;
    mem_addr_o   = '0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_wdata_o  = '0;

    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          state_d      = ST_BURST;
          owner_d      = gnt_port;
          last_owner_d = gnt_port;
          we_d         = gnt_we;
          addr_d       = gnt_addr;
          cnt_d        = gnt_len;
        end
      end
      ST_BURST: begin
        if (beat) begin
          ack_o       = port_onehot(owner_q);
          last_o      = (cnt_q == '0);
          mem_addr_o  = addr_q;
          mem_write_o = we_q;
          mem_read_o  = ~we_q;
          mem_wdata_o = own_wdata;
          addr_d      = addr_q + ADDR_W'(1);
          cnt_d       = cnt_q - LEN_W'(1);
          if (!we_q) begin
            rvalid_d = port_onehot(owner_q);
            rdata_d  = mem_rdata_i;
          end
          if (cnt_q == '0) state_d = ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      rvalid_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand-written
// burst/abort/reset sequences and a randomized run against a beat-level model.
module tb_dmem_arbiter;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int LW = 3;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [1:0]      req_i, we_i;
  logic [2*AW-1:0] addr_i;
  logic [2*LW-1:0] len_i;
  logic [2*DW-1:0] wdata_i;
  logic [1:0]      ack_o, rvalid_o;
  logic            last_o;
  logic [DW-1:0]   rdata_o, mem_wdata_o, mem_rdata_i;
  logic [AW-1:0]   mem_addr_o;
  logic            mem_read_o, mem_write_o;

  logic [DW-1:0]   tbmem  [128];
  logic [DW-1:0]   refmem [128];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .len_i       (len_i),
    .wdata_i     (wdata_i),
    .ack_o       (ack_o),
    .last_o      (last_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .mem_addr_o  (mem_addr_o),
    .mem_read_o  (mem_read_o),
    .mem_write_o (mem_write_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (mem_write_o) tbmem[mem_addr_o] <= mem_wdata_o;
  assign mem_rdata_i = tbmem[mem_addr_o];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    req_i = '0; we_i = '0; addr_i = '0; len_i = '0; wdata_i = '0;
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk_i);
    clear_inputs();
    rst_i = 1'b0;
    #1;
    chk("reset_ack", 64'(ack_o), 64'd0);
    chk("reset_rvalid", 64'(rvalid_o), 64'd0);
    chk("reset_rdata", 64'(rdata_o), 64'd0);
    chk("reset_memctl", {62'd0, mem_read_o, mem_write_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [1:0] exp_ack;
    logic       exp_last;
    logic [1:0] exp_rvalid;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [10];

  // Beat-level reference model state.
  logic          m_busy, m_owner, m_lo, m_we, m_pv, m_pp;
  logic [AW-1:0] m_addr;
  int            m_rem;
  logic [DW-1:0] m_rdata;

  logic          r_on   [2];
  logic          r_cool [2];
  logic [AW-1:0] r_addr [2];
  logic [LW-1:0] r_len  [2];
  logic          r_we   [2];
  logic [DW-1:0] r_data [2];

  initial begin
    int acks, last_at, pulses, reads, first1, cyc0;
    logic act, w;
    logic [1:0] e_ack, e_rv;

    rst_i = 1'b0;
    clear_inputs();
    for (int i = 0; i < 128; i++) tbmem[i] = 32'(i) * 32'h0101_0101 + 32'h55;

    // Contention and alternation of single-beat reads from reset.
    vecs[0] = '{2'b11, 2'b00, 1'b0, 2'b00, 32'h0};
    vecs[1] = '{2'b11, 2'b01, 1'b1, 2'b00, 32'h0};
    vecs[2] = '{2'b10, 2'b00, 1'b0, 2'b01, 32'h1111_0000};
    vecs[3] = '{2'b10, 2'b10, 1'b1, 2'b00, 32'h0};
    vecs[4] = '{2'b00, 2'b00, 1'b0, 2'b10, 32'h2222_0000};
    vecs[5] = '{2'b11, 2'b00, 1'b0, 2'b00, 32'h0};
    vecs[6] = '{2'b11, 2'b01, 1'b1, 2'b00, 32'h0};
    vecs[7] = '{2'b10, 2'b00, 1'b0, 2'b01, 32'h1111_0000};
    vecs[8] = '{2'b10, 2'b10, 1'b1, 2'b00, 32'h0};
    vecs[9] = '{2'b00, 2'b00, 1'b0, 2'b10, 32'h2222_0000};
    tbmem[10] = 32'h1111_0000;
    tbmem[20] = 32'h2222_0000;
    do_reset();
    addr_i = {7'd20, 7'd10};
    for (int i = 0; i < 10; i++) begin
      req_i = vecs[i].req;
      #1;
      chk($sformatf("vec%0d_ack", i), 64'(ack_o), 64'(vecs[i].exp_ack));
      chk($sformatf("vec%0d_last", i), 64'(last_o), 64'(vecs[i].exp_last));
      chk($sformatf("vec%0d_rvalid", i), 64'(rvalid_o), 64'(vecs[i].exp_rvalid));
      if (vecs[i].exp_rvalid != 2'b00)
        chk($sformatf("vec%0d_rdata", i), 64'(rdata_o), 64'(vecs[i].exp_rdata));
      @(negedge clk_i);
    end

    // Single-beat read of 0xDEADBEEF.
    tbmem[5] = 32'hDEAD_BEEF;
    do_reset();
    req_i = 2'b01; addr_i = {7'd0, 7'd5};
    #1; chk("rd1_idle_ack", 64'(ack_o), 64'd0);
    @(negedge clk_i); #1;
    chk("rd1_ack", 64'(ack_o), 64'b01);
    chk("rd1_last", 64'(last_o), 64'd1);
    chk("rd1_addr", 64'(mem_addr_o), 64'd5);
    chk("rd1_read", 64'(mem_read_o), 64'd1);
    @(negedge clk_i); req_i = 2'b00; #1;
    chk("rd1_rvalid", 64'(rvalid_o), 64'b01);
    chk("rd1_rdata", 64'(rdata_o), 64'hDEAD_BEEF);
    chk("rd1_ack_after", 64'(ack_o), 64'd0);
    @(negedge clk_i); #1;
    chk("rd1_rvalid_once", 64'(rvalid_o), 64'd0);

    // Port1 4-beat write wrapping 126,127,0,1.
    tbmem[126] = '1; tbmem[127] = '1; tbmem[0] = '1; tbmem[1] = '1;
    do_reset();
    req_i = 2'b10; we_i = 2'b10; addr_i = {7'd126, 7'd0}; len_i = {3'd3, 3'd0};
    wdata_i = {32'd1, 32'd0};
    acks = 0; last_at = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ack_o[1]) begin
        acks++;
        if (last_o) last_at = acks;
      end
      @(negedge clk_i);
      if (last_at != 0) req_i = 2'b00;
      wdata_i[63:32] = 32'(acks + 1);
    end
    chk("wr4_acks", 64'(acks), 64'd4);
    chk("wr4_last_beat", 64'(last_at), 64'd4);
    chk("wr4_mem126", 64'(tbmem[126]), 64'd1);
    chk("wr4_mem127", 64'(tbmem[127]), 64'd2);
    chk("wr4_mem0", 64'(tbmem[0]), 64'd3);
    chk("wr4_mem1", 64'(tbmem[1]), 64'd4);

    // Port0 8-beat read aborted after 3 acks, port1 pending.
    for (int i = 40; i < 48; i++) tbmem[i] = 32'hA000_0000 + 32'(i);
    do_reset();
    req_i = 2'b11; addr_i = {7'd90, 7'd40}; len_i = {3'd0, 3'd7};
    acks = 0; pulses = 0; reads = 0; first1 = -1; last_at = 0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (mem_read_o) reads++;
      if (ack_o[0]) acks++;
      if (ack_o[1] && first1 < 0) first1 = c;
      if (ack_o[1] && last_o) last_at = 1;
      if (rvalid_o[0]) begin
        chk($sformatf("abort_rdata%0d", pulses), 64'(rdata_o), 64'(32'hA000_0000 + 32'(40 + pulses)));
        pulses++;
      end
      @(negedge clk_i);
      if (acks == 3) req_i[0] = 1'b0;
      if (last_at != 0) req_i[1] = 1'b0;
    end
    chk("abort_acks0", 64'(acks), 64'd3);
    chk("abort_rvalid0", 64'(pulses), 64'd3);
    chk("abort_reads", 64'(reads), 64'd4);
    chk("abort_port1_cycle", 64'(first1), 64'd6);

    // Reset during beat 2 of a 4-beat write.
    for (int i = 60; i < 64; i++) tbmem[i] = '0;
    do_reset();
    req_i = 2'b01; we_i = 2'b01; addr_i = {7'd0, 7'd60}; len_i = {3'd0, 3'd3};
    wdata_i = {32'd0, 32'hA1};
    @(negedge clk_i); #1;
    chk("rst_beat1_ack", 64'(ack_o), 64'b01);
    @(negedge clk_i); wdata_i[31:0] = 32'hA2; #1;
    chk("rst_beat2_ack", 64'(ack_o), 64'b01);
    #2; rst_i = 1'b0; #1;
    chk("rst_async_ack", 64'(ack_o), 64'd0);
    chk("rst_async_write", 64'(mem_write_o), 64'd0);
    chk("rst_async_last", 64'(last_o), 64'd0);
    @(negedge clk_i); req_i = 2'b00; rst_i = 1'b1;
    acks = 0; pulses = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (ack_o != 2'b00) acks++;
      if (rvalid_o != 2'b00) pulses++;
      @(negedge clk_i);
    end
    chk("rst_no_acks", 64'(acks), 64'd0);
    chk("rst_no_rvalid", 64'(pulses), 64'd0);
    chk("rst_mem60", 64'(tbmem[60]), 64'hA1);
    chk("rst_mem61", 64'(tbmem[61]), 64'd0);

    // Port1 held through a port0 8-beat write.
    do_reset();
    req_i = 2'b11; we_i = 2'b01; addr_i = {7'd3, 7'd100}; len_i = {3'd0, 3'd7};
    acks = 0; first1 = -1; last_at = 0; cyc0 = -1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ack_o[0]) begin acks++; if (last_o) cyc0 = c; end
      if (ack_o[1] && first1 < 0) first1 = c;
      if (ack_o[1] && last_o) last_at = 1;
      @(negedge clk_i);
      if (cyc0 >= 0) req_i[0] = 1'b0;
      if (last_at != 0) req_i[1] = 1'b0;
    end
    chk("hold_acks0", 64'(acks), 64'd8);
    chk("hold_last0_cycle", 64'(cyc0), 64'd8);
    chk("hold_port1_cycle", 64'(first1), 64'd10);

    // Randomized traffic against the beat-level model.
    do_reset();
    refmem = tbmem;
    m_busy = 0; m_owner = 0; m_lo = 1; m_we = 0; m_pv = 0; m_pp = 0;
    m_addr = '0; m_rem = 0; m_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      r_on[p] = 0; r_cool[p] = 0; r_addr[p] = '0; r_len[p] = '0; r_we[p] = 0; r_data[p] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!r_on[p]) begin
          if (r_cool[p]) r_cool[p] = 0;
          else if ($urandom_range(0, 2) == 0) begin
            r_on[p] = 1; r_addr[p] = AW'($urandom); r_len[p] = LW'($urandom);
            r_we[p] = 1'($urandom); r_data[p] = $urandom;
          end
        end else if (m_busy && m_owner == 1'(p) && $urandom_range(0, 15) == 0) begin
          r_on[p] = 0; r_cool[p] = 1;
        end
      end
      req_i   = {r_on[1], r_on[0]};
      we_i    = {r_we[1], r_we[0]};
      addr_i  = {r_addr[1], r_addr[0]};
      len_i   = {r_len[1], r_len[0]};
      wdata_i = {r_data[1], r_data[0]};

      act   = m_busy && req_i[m_owner];
      e_ack = act ? (2'b01 << m_owner) : 2'b00;
      e_rv  = m_pv ? (2'b01 << m_pp) : 2'b00;
      #1;
      chk("rnd_ack", 64'(ack_o), 64'(e_ack));
      chk("rnd_last", 64'(last_o), 64'(act && m_rem == 1));
      chk("rnd_memctl", {62'd0, mem_read_o, mem_write_o}, {62'd0, act && !m_we, act && m_we});
      chk("rnd_addr", 64'(mem_addr_o), act ? 64'(m_addr) : 64'd0);
      chk("rnd_wdata", 64'(mem_wdata_o), act ? 64'(r_data[m_owner]) : 64'd0);
      chk("rnd_rvalid", 64'(rvalid_o), 64'(e_rv));
      if (e_rv != 2'b00) chk("rnd_rdata", 64'(rdata_o), 64'(m_rdata));

      m_pv = act && !m_we;
      if (m_pv) begin m_pp = m_owner; m_rdata = refmem[m_addr]; end
      if (act && m_we) refmem[m_addr] = r_data[m_owner];
      if (!m_busy) begin
        if (req_i != 2'b00) begin
          w = (req_i == 2'b11) ? !m_lo : req_i[1];
          m_busy = 1; m_owner = w; m_lo = w; m_we = we_i[w];
          m_addr = w ? addr_i[2*AW-1:AW] : addr_i[AW-1:0];
          m_rem  = 1 + int'(w ? len_i[2*LW-1:LW] : len_i[LW-1:0]);
        end
      end else if (!act) begin
        m_busy = 0;
      end else begin
        m_addr = m_addr + 1'b1;
        m_rem--;
        if (m_rem == 0) m_busy = 0;
      end

      for (int p = 0; p < 2; p++) begin
        if (e_ack[p]) begin
          if (act && m_rem == 0) begin r_on[p] = 0; r_cool[p] = 1; end
          r_data[p] = $urandom;
        end
      end
      @(negedge clk_i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
